// File: rtl/pipe_mdu_stall_ctrl_if.sv
// ID/EX hazard and MDU control bundle for the ID-stage interlock controller.
// master = pipeline side driving ID/EX fields; slave = the interlock controller.
interface pipe_mdu_stall_ctrl_if;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic        id_is_mul;
   logic        id_is_div;
   logic        id_rd_hilo;
   logic [4:0]  ern;
   logic        ewreg;
   logic        em2reg;
   logic        wpcir;
   logic        bubble;
   logic        mdu_start;
   logic        mdu_div;
   logic        mdu_busy;
   logic [15:0] stall_cnt;

   modport master (
      output id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_is_mul, id_is_div, id_rd_hilo, ern, ewreg, em2reg,
      input  wpcir, bubble, mdu_start, mdu_div, mdu_busy, stall_cnt
   );

   modport slave (
      input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt,
             id_is_mul, id_is_div, id_rd_hilo, ern, ewreg, em2reg,
      output wpcir, bubble, mdu_start, mdu_div, mdu_busy, stall_cnt
   );
endinterface

// File: rtl/pipe_mdu_stall_ctrl.sv
// ID-stage interlock: load-use detection against EX plus launch/occupancy
// tracking of a multi-cycle multiply/divide unit that blocks later MDU ops and HI/LO reads.
module pipe_mdu_stall_ctrl #(
   parameter int unsigned MUL_CYCLES = 4,
   parameter int unsigned DIV_CYCLES = 33,
   parameter int unsigned CW         = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   pipe_mdu_stall_ctrl_if.slave  bus
);

   typedef enum logic {RUN, BUSY} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [15:0]     stall_cnt_q, stall_cnt_d;

   logic load_use;
   logic mdu_op;
   logic hilo_rd;
   logic stall;
   logic start;
   logic div_sel;

   always_comb begin
      load_use = bus.id_valid & bus.ewreg & bus.em2reg & (bus.ern != 5'd0) &
                 ((bus.id_use_rs & (bus.ern == bus.id_rs)) |
                  (bus.id_use_rt & (bus.ern == bus.id_rt)));
      mdu_op   = bus.id_valid & (bus.id_is_mul | bus.id_is_div);
      hilo_rd  = bus.id_valid & bus.id_rd_hilo;
      stall    = load_use | ((state_q == BUSY) & (mdu_op | hilo_rd));
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      start   = 1'b0;
      div_sel = 1'b0;
      case (state_q)
         RUN: begin
            // A load-use stall defers the launch; the op is retried while held in ID.
            if (mdu_op && !load_use) begin
               start   = 1'b1;
               div_sel = bus.id_is_div;
               cnt_d   = bus.id_is_div ? CW'(DIV_CYCLES - 1) : CW'(MUL_CYCLES - 1);
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (cnt_q == '0) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q - CW'(1);
            end
         end
         default: state_d = RUN;
      endcase

      stall_cnt_d = stall_cnt_q;
      if (stall && (stall_cnt_q != '1)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= RUN;
         cnt_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.wpcir     = ~stall;
   assign bus.bubble    = stall;
   assign bus.mdu_start = start;
   assign bus.mdu_div   = div_sel;
   assign bus.mdu_busy  = (state_q == BUSY);
   assign bus.stall_cnt = stall_cnt_q;

endmodule
